// File: rtl/wb_rr_arbiter_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter: FSM state
// encodings and a width helper for the watchdog counter.
package wb_rr_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating-priority picker: grants the first requester found scanning upward
// from the slot after the one-hot last grant, wrapping around.
module wb_rr_pick #(
  parameter int NM = 2
) (
  input  logic [NM-1:0] req_i,
  input  logic [NM-1:0] last_i,
  output logic [NM-1:0] gnt_o
);

  logic found;

  // The last grant is scanned last, so a master that just released has lowest priority.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (last_i[i]) begin
        for (int k = 1; k <= NM; k++) begin
          if (!found && req_i[(i + k) % NM]) begin
            gnt_o[(i + k) % NM] = 1'b1;
            found = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B3 classic arbiter sharing one slave port between NM
// masters, with grant held for a whole bus cycle and a stalled-slave watchdog.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  input  logic [NM*AW-1:0]     wbm_adr_i,
  input  logic [NM*DW-1:0]     wbm_dat_i,
  input  logic [NM*DW/8-1:0]   wbm_sel_i,
  input  logic [NM-1:0]        wbm_we_i,
  input  logic [NM-1:0]        wbm_cyc_i,
  input  logic [NM-1:0]        wbm_stb_i,
  output logic [DW-1:0]        wbm_dat_o,
  output logic [NM-1:0]        wbm_ack_o,
  output logic [NM-1:0]        wbm_err_o,
  output logic [AW-1:0]        wbs_adr_o,
  output logic [DW-1:0]        wbs_dat_o,
  output logic [DW/8-1:0]      wbs_sel_o,
  output logic                 wbs_we_o,
  output logic                 wbs_cyc_o,
  output logic                 wbs_stb_o,
  input  logic [DW-1:0]        wbs_dat_i,
  input  logic                 wbs_ack_i,
  input  logic                 wbs_err_i,
  output logic [NM-1:0]        grant_o
);

  localparam int SW = DW / 8;
  localparam int TW = (TIMEOUT == 0) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WdLimit  = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic [NM-1:0] LastInit = {1'b1, {(NM-1){1'b0}}};

  arb_state_e    state_q;
  logic [NM-1:0] grant_q;
  logic [NM-1:0] last_q;
  logic [TW-1:0] wdog_q;
  logic [TW-1:0] wdog_d;
  logic [NM-1:0] pick_gnt;
  logic          busy;
  logic          stall;
  logic          timeout;

  wb_rr_pick #(.NM(NM)) u_pick (
    .req_i  (wbm_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt)
  );

  assign busy = (state_q == BUSY);

  // grant_q is all-zero outside BUSY, so the OR-mux drives zeros in IDLE.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (busy && grant_q[i]) begin
        wbs_adr_o = wbs_adr_o | wbm_adr_i[i*AW +: AW];
        wbs_dat_o = wbs_dat_o | wbm_dat_i[i*DW +: DW];
        wbs_sel_o = wbs_sel_o | wbm_sel_i[i*SW +: SW];
        wbs_we_o  = wbs_we_o  | wbm_we_i[i];
        wbs_cyc_o = wbs_cyc_o | wbm_cyc_i[i];
        wbs_stb_o = wbs_stb_o | wbm_stb_i[i];
      end
    end
  end

  // Timeout fires on the TIMEOUT-th consecutive stalled strobe cycle.
  assign stall   = busy && wbs_stb_o && !wbs_ack_i && !wbs_err_i;
  assign timeout = (TIMEOUT != 0) && stall && (wdog_q == WdLimit);
  assign wdog_d  = ((TIMEOUT != 0) && stall && !timeout) ? wdog_q + TW'(1) : '0;

  assign wbm_dat_o = wbs_dat_i;
  assign wbm_ack_o = grant_q & {NM{busy && wbs_ack_i && !wbs_err_i && !timeout}};
  assign wbm_err_o = grant_q & {NM{busy && (wbs_err_i || timeout)}};
  assign grant_o   = grant_q;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LastInit;
      wdog_q  <= '0;
    end else begin
      wdog_q <= wdog_d;
      case (state_q)
        IDLE: begin
          if (|wbm_cyc_i) begin
            grant_q <= pick_gnt;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!(|(wbm_cyc_i & grant_q))) begin
            last_q  <= grant_q;
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed self-checking bench for wb_rr_arbiter with two masters and an
// 8-cycle watchdog; expected values are hand-derived per step.
module tb_wb_rr_arbiter;

  logic        wbClk = 1'b0;
  logic        wbRst;
  logic [1:0]  mCyc;
  logic [1:0]  mStb;
  logic        m0We;
  logic [31:0] wbsDat;
  logic        wbsAck;
  logic        wbsErr;

  logic [31:0] wbmDatOut;
  logic [1:0]  wbmAck;
  logic [1:0]  wbmErr;
  logic [31:0] wbsAdr;
  logic [31:0] wbsDatOut;
  logic [3:0]  wbsSel;
  logic        wbsWe;
  logic        wbsCyc;
  logic        wbsStb;
  logic [1:0]  grant;

  int total  = 0;
  int passed = 0;

  always #5 wbClk = ~wbClk;

  wb_rr_arbiter #(.NM(2), .AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk    (wbClk),
    .wb_rst    (wbRst),
    .wbm_adr_i ({32'h0000_0200, 32'h0000_0100}),
    .wbm_dat_i ({32'hB1B1_B1B1, 32'hA0A0_A0A0}),
    .wbm_sel_i ({4'h3, 4'hF}),
    .wbm_we_i  ({1'b0, m0We}),
    .wbm_cyc_i (mCyc),
    .wbm_stb_i (mStb),
    .wbm_dat_o (wbmDatOut),
    .wbm_ack_o (wbmAck),
    .wbm_err_o (wbmErr),
    .wbs_adr_o (wbsAdr),
    .wbs_dat_o (wbsDatOut),
    .wbs_sel_o (wbsSel),
    .wbs_we_o  (wbsWe),
    .wbs_cyc_o (wbsCyc),
    .wbs_stb_o (wbsStb),
    .wbs_dat_i (wbsDat),
    .wbs_ack_i (wbsAck),
    .wbs_err_i (wbsErr),
    .grant_o   (grant)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge wbClk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] cyc, input logic [1:0] stb);
    mCyc = cyc;
    mStb = stb;
  endtask

  // Called in the first BUSY cycle: ack once, release, then expect the IDLE gap.
  task automatic serveGrant(input string tag, input logic [1:0] expGrant, input logic [31:0] expAdr);
    checkOutput({tag, " grant"}, {30'd0, grant}, {30'd0, expGrant});
    checkOutput({tag, " adr"}, wbsAdr, expAdr);
    wbsAck = 1'b1;
    #1;
    checkOutput({tag, " ack"}, {30'd0, wbmAck}, {30'd0, expGrant});
    checkOutput({tag, " err"}, {30'd0, wbmErr}, 32'd0);
    tick();
    wbsAck = 1'b0;
    applyStimulus(mCyc & ~expGrant, mStb & ~expGrant);
    #1;
    checkOutput({tag, " cyc drop"}, {31'd0, wbsCyc}, 32'd0);
    tick();
    checkOutput({tag, " gap"}, {30'd0, grant}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    wbRst = 1'b1;
    applyStimulus(2'b00, 2'b00);
    m0We = 1'b0; wbsDat = 32'h0; wbsAck = 1'b0; wbsErr = 1'b0;
    #2;
    checkOutput("reset grant", {30'd0, grant}, 32'd0);
    checkOutput("reset cyc", {31'd0, wbsCyc}, 32'd0);
    tick(); tick();
    wbRst = 1'b0;

    $display("[TB] test 1: single master0 read");
    tick();
    applyStimulus(2'b01, 2'b01);
    #1;
    checkOutput("t1 latency", {30'd0, grant}, 32'd0);
    tick();
    checkOutput("t1 grant", {30'd0, grant}, 32'd1);
    checkOutput("t1 adr", wbsAdr, 32'h100);
    checkOutput("t1 stb", {31'd0, wbsStb}, 32'd1);
    checkOutput("t1 no ack", {30'd0, wbmAck}, 32'd0);
    tick();
    wbsAck = 1'b1; wbsDat = 32'hDEAD_BEEF;
    #1;
    checkOutput("t1 ack", {30'd0, wbmAck}, 32'd1);
    checkOutput("t1 data", wbmDatOut, 32'hDEAD_BEEF);
    tick();
    wbsAck = 1'b0;
    applyStimulus(2'b00, 2'b00);
    #1;
    checkOutput("t1 cyc drop", {31'd0, wbsCyc}, 32'd0);
    tick();
    checkOutput("t1 idle", {30'd0, grant}, 32'd0);

    $display("[TB] test 2: simultaneous requests, rotation");
    applyStimulus(2'b11, 2'b11);
    tick();
    serveGrant("t2a m1", 2'b10, 32'h200);
    tick();
    serveGrant("t2a m0", 2'b01, 32'h100);
    wbRst = 1'b1;
    #1;
    checkOutput("t2 reset grant", {30'd0, grant}, 32'd0);
    tick();
    wbRst = 1'b0;
    applyStimulus(2'b11, 2'b11);
    tick();
    serveGrant("t2b m0", 2'b01, 32'h100);
    tick();
    serveGrant("t2b m1", 2'b10, 32'h200);

    $display("[TB] test 3: request while busy with waited write");
    m0We = 1'b1;
    applyStimulus(2'b01, 2'b01);
    tick();
    checkOutput("t3 we", {31'd0, wbsWe}, 32'd1);
    checkOutput("t3 wdata", wbsDatOut, 32'hA0A0_A0A0);
    checkOutput("t3 sel", {28'd0, wbsSel}, 32'hF);
    applyStimulus(2'b11, 2'b11);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3 hold", {30'd0, grant}, 32'd1);
      tick();
    end
    serveGrant("t3 m0", 2'b01, 32'h100);
    m0We = 1'b0;
    tick();
    serveGrant("t3 m1", 2'b10, 32'h200);
    checkOutput("t3 m1 sel", {28'd0, wbsSel}, 32'h0);

    $display("[TB] test 4: watchdog timeout");
    applyStimulus(2'b01, 2'b01);
    tick();
    for (int k = 1; k < 8; k++) begin
      checkOutput("t4 pre err", {30'd0, wbmErr}, 32'd0);
      tick();
    end
    checkOutput("t4 pulse", {30'd0, wbmErr}, 32'd1);
    checkOutput("t4 ack blocked", {30'd0, wbmAck}, 32'd0);
    checkOutput("t4 cyc kept", {31'd0, wbsCyc}, 32'd1);
    tick();
    checkOutput("t4 post err", {30'd0, wbmErr}, 32'd0);
    applyStimulus(2'b00, 2'b00);
    tick();
    checkOutput("t4 idle", {30'd0, grant}, 32'd0);

    $display("[TB] test 5: slave error forwarding");
    applyStimulus(2'b10, 2'b10);
    tick();
    wbsErr = 1'b1;
    #1;
    checkOutput("t5 err", {30'd0, wbmErr}, 32'd2);
    checkOutput("t5 ack", {30'd0, wbmAck}, 32'd0);
    tick();
    wbsErr = 1'b0;
    applyStimulus(2'b00, 2'b00);
    tick();
    checkOutput("t5 idle", {30'd0, grant}, 32'd0);

    $display("[TB] test 6: reset mid-transfer");
    applyStimulus(2'b01, 2'b01);
    tick();
    checkOutput("t6 grant", {30'd0, grant}, 32'd1);
    #2;
    wbRst = 1'b1;
    #1;
    checkOutput("t6 rst cyc", {31'd0, wbsCyc}, 32'd0);
    checkOutput("t6 rst stb", {31'd0, wbsStb}, 32'd0);
    checkOutput("t6 rst grant", {30'd0, grant}, 32'd0);
    applyStimulus(2'b11, 2'b11);
    tick();
    wbRst = 1'b0;
    tick();
    checkOutput("t6 m0 first", {30'd0, grant}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
